// File: rtl/exec_pkg.sv
// exec_pkg: shared ALU opcodes, condition codes, FSM states and forwarding selects
package exec_pkg;
   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_ORR = 3'b011,
      ALU_EOR = 3'b100,
      ALU_MUL = 3'b101
   } alu_op_t;
   localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
                          CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
                          CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'ha, CC_LT = 4'hb,
                          CC_GT = 4'hc, CC_LE = 4'hd, CC_AL = 4'he, CC_NV = 4'hf;
   typedef enum logic {IDLE, MUL_BUSY} state_t;
   localparam logic [1:0] FWD_RD = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10;
endpackage

// File: rtl/mul_iter.sv
// mul_iter: radix-2 shift-add multiplier, one partial product per cycle, product valid combinationally with done
module mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH) + 1;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc, mcand, mplier;
   assign product = acc + (mplier[0] ? mcand : '0);
   assign done = cnt == CW'(1);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (abort) begin
         cnt <= '0;
      end else if (start) begin
         cnt    <= CW'(WIDTH);
         acc    <= '0;
         mcand  <= a;
         mplier <= b;
      end else if (cnt != '0) begin
         cnt    <= cnt - 1'b1;
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end
endmodule

// File: rtl/exec_stage.sv
// exec_stage: execute stage with forwarding, NZCV flags, ARM conditions and an iterative multiply FSM
module exec_stage
   import exec_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ValidE,
   input  logic             FlushE,
   input  logic             RegWriteE,
   input  logic             MemWriteE,
   input  logic             PCSrcE,
   input  logic             BranchE,
   input  logic             ALUSrcE,
   input  logic [1:0]       FlagWriteE,
   input  logic [2:0]       ALUControlE,
   input  logic [3:0]       CondE,
   input  logic [WIDTH-1:0] RD1E,
   input  logic [WIDTH-1:0] RD2E,
   input  logic [WIDTH-1:0] ExtImmE,
   input  logic [WIDTH-1:0] ResultW,
   input  logic [AW-1:0]    WA3E,
   input  logic [1:0]       ForwardAE,
   input  logic [1:0]       ForwardBE,
   output logic             BranchTakenE,
   output logic             BusyE,
   output logic [3:0]       FlagsQ,
   output logic             RegWriteM,
   output logic             MemWriteM,
   output logic             PCSrcM,
   output logic [WIDTH-1:0] ALUResultM,
   output logic [WIDTH-1:0] WriteDataM,
   output logic [AW-1:0]    WA3M
);
   state_t           state, state_nx;
   logic [WIDTH-1:0] src_a, src_b, write_data, b_in, alu_res, mul_prod;
   logic [WIDTH:0]   sum;
   logic             fn, fz, fc, fv, pass, cond_ex, is_sub, is_arith, is_logic;
   logic             busy, mul_start, mul_done, complete, pass_ok;
   logic [AW-1:0]    wa3_l;
   logic             rw_l;
   logic [1:0]       fw_l;
   assign src_a = ForwardAE inside {FWD_RD, 2'b11} ? RD1E : ForwardAE == FWD_W ? ResultW : ALUResultM;
   assign write_data = ForwardBE inside {FWD_RD, 2'b11} ? RD2E : ForwardBE == FWD_W ? ResultW : ALUResultM;
   assign src_b = ALUSrcE ? ExtImmE : write_data;
   assign is_sub = ALUControlE == ALU_SUB;
   assign is_arith = ALUControlE inside {ALU_ADD, ALU_SUB};
   assign is_logic = ALUControlE inside {ALU_AND, ALU_ORR, ALU_EOR};
   assign b_in = is_sub ? ~src_b : src_b;
   assign sum = {1'b0, src_a} + {1'b0, b_in} + (WIDTH+1)'(is_sub);
   always_comb begin
      alu_res = is_arith ? sum[WIDTH-1:0] :
                ALUControlE == ALU_AND ? src_a & src_b :
                ALUControlE == ALU_ORR ? src_a | src_b :
                ALUControlE == ALU_EOR ? src_a ^ src_b : '0;
   end
   assign {fn, fz, fc, fv} = FlagsQ;
   always_comb begin
      pass = 1'b0;
      case (CondE)
         CC_EQ: pass = fz;
         CC_NE: pass = ~fz;
         CC_CS: pass = fc;
         CC_CC: pass = ~fc;
         CC_MI: pass = fn;
         CC_PL: pass = ~fn;
         CC_VS: pass = fv;
         CC_VC: pass = ~fv;
         CC_HI: pass = fc & ~fz;
         CC_LS: pass = ~fc | fz;
         CC_GE: pass = fn == fv;
         CC_LT: pass = fn != fv;
         CC_GT: pass = ~fz & (fn == fv);
         CC_LE: pass = fz | (fn != fv);
         CC_AL: pass = 1'b1;
         CC_NV: pass = 1'b0;
      endcase
   end
   assign cond_ex = ValidE & ~FlushE & pass;
   assign busy = state == MUL_BUSY;
   assign mul_start = ~busy & cond_ex & (ALUControlE == ALU_MUL);
   assign complete = busy & mul_done & ~FlushE;
   assign pass_ok = cond_ex & ~mul_start;
   assign BranchTakenE = BranchE & cond_ex & ~busy;
   assign BusyE = mul_start | (busy & ~mul_done);
   always_comb begin
      state_nx = mul_start ? MUL_BUSY : busy & (FlushE | mul_done) ? IDLE : state;
   end
   mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .abort   (busy & FlushE),
      .a       (src_a),
      .b       (src_b),
      .done    (mul_done),
      .product (mul_prod)
   );
   // a MUL start or any busy cycle sends a bubble; only the completing edge writes back
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         FlagsQ     <= '0;
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         PCSrcM     <= 1'b0;
         ALUResultM <= '0;
         WriteDataM <= '0;
         WA3M       <= '0;
         wa3_l      <= '0;
         rw_l       <= 1'b0;
         fw_l       <= '0;
      end else begin
         state <= state_nx;
         if (busy) begin
            RegWriteM <= complete & rw_l;
            MemWriteM <= 1'b0;
            PCSrcM    <= 1'b0;
            if (complete) begin
               ALUResultM <= mul_prod;
               WA3M       <= wa3_l;
               if (fw_l[1]) FlagsQ[3:2] <= {mul_prod[WIDTH-1], ~|mul_prod};
            end
         end else begin
            RegWriteM  <= RegWriteE & pass_ok;
            MemWriteM  <= MemWriteE & pass_ok;
            PCSrcM     <= PCSrcE & pass_ok;
            ALUResultM <= alu_res;
            WriteDataM <= write_data;
            WA3M       <= WA3E;
            if (mul_start) begin
               wa3_l <= WA3E;
               rw_l  <= RegWriteE;
               fw_l  <= FlagWriteE;
            end
            if (cond_ex & FlagWriteE[1] & (is_arith | is_logic)) FlagsQ[3:2] <= {alu_res[WIDTH-1], ~|alu_res};
            if (cond_ex & FlagWriteE[0] & is_arith) FlagsQ[1:0] <= {sum[WIDTH], (src_a[WIDTH-1] == b_in[WIDTH-1]) & (alu_res[WIDTH-1] != src_a[WIDTH-1])};
         end
      end
   end
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed checks of exec_stage ALU, flags, conditions, forwarding and multiply FSM
module tb_exec_stage;
   import exec_pkg::*;
   logic        clk = 1'b0, rst;
   logic        ValidE, FlushE, RegWriteE, MemWriteE, PCSrcE, BranchE, ALUSrcE;
   logic [1:0]  FlagWriteE, ForwardAE, ForwardBE;
   logic [2:0]  ALUControlE;
   logic [3:0]  CondE, FlagsQ, WA3E, WA3M;
   logic [31:0] RD1E, RD2E, ExtImmE, ResultW, ALUResultM, WriteDataM;
   logic        BranchTakenE, BusyE, RegWriteM, MemWriteM, PCSrcM;
   int          total = 0, bad = 0, busy_cnt, bub_bad;
   exec_stage #(.WIDTH(32), .AW(4)) dut (
      .clk(clk), .rst(rst), .ValidE(ValidE), .FlushE(FlushE), .RegWriteE(RegWriteE),
      .MemWriteE(MemWriteE), .PCSrcE(PCSrcE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
      .FlagWriteE(FlagWriteE), .ALUControlE(ALUControlE), .CondE(CondE), .RD1E(RD1E),
      .RD2E(RD2E), .ExtImmE(ExtImmE), .ResultW(ResultW), .WA3E(WA3E), .ForwardAE(ForwardAE),
      .ForwardBE(ForwardBE), .BranchTakenE(BranchTakenE), .BusyE(BusyE), .FlagsQ(FlagsQ),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .PCSrcM(PCSrcM), .ALUResultM(ALUResultM),
      .WriteDataM(WriteDataM), .WA3M(WA3M)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic op(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] fw, input logic [3:0] cc, input logic rw, input logic [3:0] wa);
      ValidE = 1'b1; FlushE = 1'b0; ALUControlE = ctl; RD1E = a; RD2E = b; FlagWriteE = fw;
      CondE = cc; RegWriteE = rw; WA3E = wa; MemWriteE = 1'b0; PCSrcE = 1'b0; BranchE = 1'b0;
      ALUSrcE = 1'b0; ForwardAE = FWD_RD; ForwardBE = FWD_RD; ExtImmE = '0; ResultW = '0;
   endtask
   task automatic idle();
      op(ALU_ADD, 0, 0, 2'b00, CC_AL, 1'b0, 4'h0);
      ValidE = 1'b0;
   endtask
   initial begin
      rst = 1'b0;
      idle();
      #3;
      chk("rst_flags", FlagsQ, 4'b0000);
      chk("rst_regwrite", RegWriteM, 0);
      chk("rst_result", ALUResultM, 0);
      chk("rst_busy", BusyE, 0);
      tick();
      rst = 1'b1;
      // SUB 5-5 sets Z and C
      op(ALU_SUB, 5, 5, 2'b11, CC_AL, 1'b1, 4'h3);
      MemWriteE = 1'b1;
      #1 chk("sub_busy", BusyE, 0);
      tick();
      chk("sub_flags", FlagsQ, 4'b0110);
      chk("sub_result", ALUResultM, 0);
      chk("sub_regwrite", RegWriteM, 1);
      chk("sub_memwrite", MemWriteM, 1);
      chk("sub_wa3", WA3M, 3);
      chk("sub_wdata", WriteDataM, 5);
      op(ALU_ADD, 0, 0, 2'b00, CC_EQ, 1'b0, 4'h0);
      BranchE = 1'b1; PCSrcE = 1'b1;
      #1 chk("beq_taken", BranchTakenE, 1);
      CondE = CC_NE;
      #1 chk("bne_taken", BranchTakenE, 0);
      CondE = CC_NV;
      #1 chk("bnv_taken", BranchTakenE, 0);
      tick();
      chk("bnv_pcsrc", PCSrcM, 0);
      // ADD overflow: N=1 Z=0 C=0 V=1
      op(ALU_ADD, 32'h7fffffff, 1, 2'b11, CC_AL, 1'b1, 4'h1);
      tick();
      chk("ovf_flags", FlagsQ, 4'b1001);
      chk("ovf_result", ALUResultM, 32'h80000000);
      op(ALU_ADD, 0, 0, 2'b00, CC_GE, 1'b0, 4'h0);
      BranchE = 1'b1;
      #1 chk("bge_taken", BranchTakenE, 1);
      CondE = CC_LT;
      #1 chk("blt_taken", BranchTakenE, 0);
      CondE = CC_VS;
      #1 chk("bvs_taken", BranchTakenE, 1);
      CondE = CC_CS;
      #1 chk("bcs_taken", BranchTakenE, 0);
      CondE = CC_GT;
      #1 chk("bgt_taken", BranchTakenE, 1);
      // forwarding
      op(ALU_ADD, 3, 4, 2'b00, CC_AL, 1'b1, 4'h5);
      tick();
      chk("add34_result", ALUResultM, 7);
      op(ALU_ADD, 100, 10, 2'b00, CC_AL, 1'b1, 4'h6);
      ForwardAE = FWD_M;
      tick();
      chk("fwd_m_result", ALUResultM, 17);
      op(ALU_ADD, 100, 1, 2'b00, CC_AL, 1'b1, 4'h6);
      ForwardAE = FWD_W; ForwardBE = 2'b11; ResultW = 20;
      tick();
      chk("fwd_w_result", ALUResultM, 21);
      op(ALU_SUB, 12, 99, 2'b00, CC_AL, 1'b1, 4'h7);
      ALUSrcE = 1'b1; ExtImmE = 5;
      tick();
      chk("imm_result", ALUResultM, 7);
      chk("imm_wdata", WriteDataM, 99);
      chk("nofw_flags", FlagsQ, 4'b1001);
      // logic op touches only N and Z
      op(ALU_EOR, 32'hf0, 32'hf0, 2'b11, CC_AL, 1'b1, 4'h2);
      tick();
      chk("eor_flags", FlagsQ, 4'b0101);
      op(ALU_ORR, 32'h0f, 32'hf0, 2'b00, CC_AL, 1'b1, 4'h2);
      tick();
      chk("orr_result", ALUResultM, 32'hff);
      op(ALU_SUB, 1, 2, 2'b11, CC_NE, 1'b1, 4'h2);
      tick();
      chk("fail_flags", FlagsQ, 4'b0101);
      chk("fail_regwrite", RegWriteM, 0);
      op(3'b110, 5, 3, 2'b11, CC_AL, 1'b1, 4'h2);
      tick();
      chk("op6_result", ALUResultM, 0);
      chk("op6_flags", FlagsQ, 4'b0101);
      // MUL 7*6
      op(ALU_MUL, 7, 6, 2'b10, CC_AL, 1'b1, 4'h9);
      busy_cnt = 0; bub_bad = 0;
      for (int k = 1; k <= 33; k++) begin
         #1;
         busy_cnt += int'(BusyE);
         if (k == 33) chk("mul_busy_last", BusyE, 0);
         tick();
         if (k == 1) begin
            op(ALU_ADD, 1, 1, 2'b11, CC_AL, 1'b1, 4'h4);
            MemWriteE = 1'b1; PCSrcE = 1'b1;
         end
         if (k < 33 && (RegWriteM || MemWriteM || PCSrcM)) bub_bad++;
      end
      chk("mul_busy_cycles", busy_cnt, 32);
      chk("mul_bubbles", bub_bad, 0);
      chk("mul_result", ALUResultM, 42);
      chk("mul_regwrite", RegWriteM, 1);
      chk("mul_memwrite", MemWriteM, 0);
      chk("mul_wa3", WA3M, 9);
      chk("mul_flags", FlagsQ, 4'b0001);
      idle();
      tick();
      chk("mul_after_regwrite", RegWriteM, 0);
      // flush during MUL_BUSY cycle 10; 0*5 would otherwise set Z
      op(ALU_MUL, 0, 5, 2'b10, CC_AL, 1'b1, 4'h8);
      tick();
      idle();
      bub_bad = 0;
      for (int k = 2; k <= 10; k++) begin
         tick();
         if (RegWriteM) bub_bad++;
      end
      FlushE = 1'b1;
      tick();
      FlushE = 1'b0;
      #1 chk("flush_idle_busy", BusyE, 0);
      for (int k = 0; k < 30; k++) begin
         tick();
         if (RegWriteM) bub_bad++;
      end
      chk("flush_no_write", bub_bad, 0);
      chk("flush_flags", FlagsQ, 4'b0001);
      op(ALU_MUL, 2, 3, 2'b10, CC_AL, 1'b1, 4'h8);
      FlushE = 1'b1;
      #1 chk("flush_start_busy", BusyE, 0);
      tick();
      idle();
      #1 chk("flush_start_idle", BusyE, 0);
      // reset mid-multiply
      op(ALU_MUL, 7, 6, 2'b10, CC_AL, 1'b1, 4'hc);
      tick();
      idle();
      repeat (5) tick();
      #2 rst = 1'b0;
      #1;
      chk("arst_regwrite", RegWriteM, 0);
      chk("arst_memwrite", MemWriteM, 0);
      chk("arst_pcsrc", PCSrcM, 0);
      chk("arst_result", ALUResultM, 0);
      chk("arst_wdata", WriteDataM, 0);
      chk("arst_wa3", WA3M, 0);
      chk("arst_flags", FlagsQ, 4'b0000);
      chk("arst_busy", BusyE, 0);
      tick();
      rst = 1'b1;
      bub_bad = 0;
      for (int k = 0; k < 35; k++) begin
         tick();
         if (RegWriteM || BusyE) bub_bad++;
      end
      chk("arst_no_write", bub_bad, 0);
      op(ALU_ADD, 1, 1, 2'b00, CC_AL, 1'b1, 4'h1);
      tick();
      chk("post_rst_add", ALUResultM, 2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
